// File: rtl/tmr_vote_pipe.sv
// Triple-modular-redundant register pipeline: three replicas of DEPTH stages, majority voters between
// stages and at the outputs, mismatch tracking and a fault-injection port for exercising the voting.
module tmr_vote_pipe #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8,
    parameter int STG_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 inj_en,
    input  logic [1:0]           inj_rep,
    input  logic [STG_W-1:0]     inj_stage,
    input  logic [WIDTH-1:0]     inj_mask,
    input  logic                 err_clr,
    output logic [2:0]           out_valid,
    output logic [WIDTH-1:0]     out_data_0,
    output logic [WIDTH-1:0]     out_data_1,
    output logic [WIDTH-1:0]     out_data_2,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           err_rep
);
    // Each stored entry is {valid, data}, so a single voter covers both fields.
    localparam int EW = WIDTH + 1;

    function automatic logic [EW-1:0] maj(input logic [EW-1:0] a,
                                          input logic [EW-1:0] b,
                                          input logic [EW-1:0] c);
        return (a & b) | (b & c) | (c & a);
    endfunction

    logic [2:0][DEPTH-1:0][EW-1:0] q;
    logic [2:0][DEPTH-1:0][EW-1:0] q_nxt;
    logic [DEPTH-1:0][2:0]         stg_odd;
    logic [DEPTH-1:0]              stg_mis;
    logic [2:0]                    odd_any;
    logic [2:0][EW-1:0]            out_q;

    for (genvar k = 0; k < 3; k++) begin : g_rep
        for (genvar s = 0; s < DEPTH; s++) begin : g_stg
            logic [EW-1:0] src;
            logic          hit;
            if (s == 0) begin : g_in
                assign src = {in_valid, in_data};
            end else begin : g_vote
                assign src = maj(q[0][s-1], q[1][s-1], q[2][s-1]);
            end
            // Out-of-range replica or stage selects match no generate instance, so they do nothing.
            assign hit         = inj_en && (inj_rep == 2'(k)) && (inj_stage == STG_W'(s));
            assign q_nxt[k][s] = hit ? (src ^ {1'b0, inj_mask}) : src;
        end
        assign out_q[k] = maj(q[0][DEPTH-1], q[1][DEPTH-1], q[2][DEPTH-1]);
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_chk
        logic [EW-1:0] m;
        assign m          = maj(q[0][s], q[1][s], q[2][s]);
        assign stg_odd[s] = {q[2][s] != m, q[1][s] != m, q[0][s] != m};
        assign stg_mis[s] = |stg_odd[s];
    end

    always_comb begin
        // NOTE: default assigned before the loop so every path drives odd_any and no latch is inferred.
        odd_any = '0;
        for (int s = 0; s < DEPTH; s++) begin
            odd_any = odd_any | stg_odd[s];
        end
    end

    assign out_data_0 = out_q[0][WIDTH-1:0];
    assign out_data_1 = out_q[1][WIDTH-1:0];
    assign out_data_2 = out_q[2][WIDTH-1:0];
    assign out_valid  = {out_q[2][WIDTH], out_q[1][WIDTH], out_q[0][WIDTH]};

    // NOTE: non-blocking assignments so every register samples pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the replica registers are reset too, so out_valid is defined right after reset.
            q        <= '0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
            err_rep  <= '0;
        end else begin
            q        <= q_nxt;
            err_flag <= |stg_mis;
            if (err_clr) begin
                err_cnt <= '0;
                err_rep <= '0;
            end else begin
                if ((|stg_mis) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
                err_rep <= err_rep | odd_any;
            end
        end
    end

endmodule
